// File: rtl/uart_reg_pkg.sv
// Shared encodings and helpers for the UART register-file slave.
// Holds the receive/command state types, default bit period and odd-parity helper.
package uart_reg_pkg;

  localparam int DEFAULT_BIT_CYC = 434;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    WAIT_CMD,
    WAIT_WDATA,
    READ_GAP,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } cmd_state_t;

  function automatic logic odd_par(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampling UART byte receiver: 2-flop synchronizer, start-bit glitch filter,
// 8N-odd-parity deserializer with a one-cycle byte_vld strobe after the stop sample.
module uart_rx_byte
  import uart_reg_pkg::*;
#(
  parameter int BIT_CYC = DEFAULT_BIT_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       par_ok,
  output logic       stop_ok,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] MID  = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYC - 1);

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             par_ok_nxt, stop_ok_nxt, byte_vld_nxt;
  logic             rx_meta, rx_s, rx_d;

  // Synchronizer plus one extra delayed copy for falling-edge detection; idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_ok   <= 1'b0;
      stop_ok  <= 1'b0;
      byte_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      clk_cnt  <= clk_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      par_ok   <= par_ok_nxt;
      stop_ok  <= stop_ok_nxt;
      byte_vld <= byte_vld_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clk_cnt_nxt  = clk_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    par_ok_nxt   = par_ok;
    stop_ok_nxt  = stop_ok;
    byte_vld_nxt = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_d && !rx_s) begin
          state_nxt   = RX_START;
          clk_cnt_nxt = '0;
        end
      end
      // After the mid-start sample the counter runs a full bit, so later samples stay mid-bit.
      RX_START: begin
        if (clk_cnt == MID) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt == LAST) begin
          clk_cnt_nxt = '0;
          shreg_nxt   = {rx_s, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (clk_cnt == LAST) begin
          clk_cnt_nxt = '0;
          par_ok_nxt  = (rx_s == odd_par(shreg));
          state_nxt   = RX_STOP;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (clk_cnt == LAST) begin
          clk_cnt_nxt  = '0;
          stop_ok_nxt  = rx_s;
          byte_vld_nxt = 1'b1;
          state_nxt    = RX_IDLE;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign rx_byte = shreg;
  assign rx_busy = (state != RX_IDLE);

endmodule

// File: rtl/uart_reg_slave.sv
// UART register-file slave: decodes {rw, addr} commands, writes the register
// array or serializes an odd-parity read reply back on tx.
module uart_reg_slave
  import uart_reg_pkg::*;
#(
  parameter int ADDR_W        = 7,
  parameter int BIT_CYC       = DEFAULT_BIT_CYC,
  parameter int TURNAROUND    = 16,
  parameter int WDATA_TIMEOUT = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              tx,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              err_parity,
  output logic              err_frame,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BIT_CYC / 2 - 1 + TURNAROUND - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(WDATA_TIMEOUT - 1);

  logic              byte_vld, par_ok, stop_ok, rx_busy;
  logic [7:0]        rx_byte;

  cmd_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [7:0]        rdata, rdata_nxt;
  logic              reg_we, err_par_nxt, err_frm_nxt, tx_nxt;
  logic [7:0]        regs [DEPTH];

  uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .byte_vld (byte_vld),
    .rx_byte  (rx_byte),
    .par_ok   (par_ok),
    .stop_ok  (stop_ok),
    .rx_busy  (rx_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_CMD;
      cnt        <= '0;
      bit_cnt    <= '0;
      addr       <= '0;
      rdata      <= '0;
      tx         <= 1'b1;
      wr_pulse   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      addr       <= addr_nxt;
      rdata      <= rdata_nxt;
      tx         <= tx_nxt;
      wr_pulse   <= reg_we;
      err_parity <= err_par_nxt;
      err_frame  <= err_frm_nxt;
      if (reg_we) begin
        wr_addr <= addr;
        wr_data <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[addr] <= rx_byte;
    end
  end

  // One shared counter serves the write-data timeout, the read turnaround and the TX bit period.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    addr_nxt    = addr;
    rdata_nxt   = rdata;
    reg_we      = 1'b0;
    err_par_nxt = 1'b0;
    err_frm_nxt = 1'b0;
    tx_nxt      = 1'b1;
    case (state)
      WAIT_CMD: begin
        if (byte_vld) begin
          if (!par_ok || !stop_ok) begin
            err_par_nxt = !par_ok;
            err_frm_nxt = !stop_ok;
          end else begin
            addr_nxt = rx_byte[ADDR_W-1:0];
            cnt_nxt  = '0;
            if (rx_byte[7]) begin
              state_nxt = WAIT_WDATA;
            end else begin
              rdata_nxt = regs[rx_byte[ADDR_W-1:0]];
              state_nxt = READ_GAP;
            end
          end
        end
      end
      // A byte already in flight at the deadline is allowed to finish.
      WAIT_WDATA: begin
        if (byte_vld) begin
          if (par_ok && stop_ok) begin
            reg_we = 1'b1;
          end else begin
            err_par_nxt = !par_ok;
            err_frm_nxt = !stop_ok;
          end
          state_nxt = WAIT_CMD;
        end else if (cnt == TO_LAST) begin
          if (!rx_busy) begin
            err_frm_nxt = 1'b1;
            state_nxt   = WAIT_CMD;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      READ_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = TX_START;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      TX_START: begin
        tx_nxt = 1'b0;
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          state_nxt   = TX_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        tx_nxt = rdata[bit_cnt];
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = TX_PARITY;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      TX_PARITY: begin
        tx_nxt = odd_par(rdata);
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = TX_STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_CMD;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = WAIT_CMD;
    endcase
  end

  assign busy     = (state != WAIT_CMD);
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_uart_reg_slave.sv
// Directed self-checking bench for uart_reg_slave: write/read loop, parity and
// stop-bit errors, write-data timeout, glitch rejection and reset during a reply.
module tb_uart_reg_slave;

  localparam int BIT_CYC = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tx, wr_pulse, err_parity, err_frame, busy;
  logic [6:0] wr_addr;
  logic [6:0] dbg_addr = 7'd0;
  logic [7:0] wr_data, dbg_data;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_count = 0, perr_count = 0, ferr_count = 0;
  int busy_rise_cyc = 0, ferr_cyc = 0;
  logic       busy_q = 1'b0, busy_at_ferr = 1'b0;
  logic [6:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;

  always #5 clk = ~clk;

  uart_reg_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .tx         (tx),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .busy       (busy),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Strobe monitor sampled on the inactive edge.
  always @(negedge clk) begin
    cyc++;
    if (wr_pulse) begin
      wr_count++;
      last_wr_addr = wr_addr;
      last_wr_data = wr_data;
    end
    if (err_parity) perr_count++;
    if (err_frame) begin
      ferr_count++;
      ferr_cyc = cyc;
      busy_at_ferr = busy;
    end
    if (busy && !busy_q) busy_rise_cyc = cyc;
    busy_q = busy;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic par_flip, input logic stop_val);
    logic [10:0] bits;
    bits = {stop_val, (~^data) ^ par_flip, data, 1'b0};
    @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      #1 rx = bits[i];
      repeat (BIT_CYC) @(posedge clk);
    end
  endtask

  task automatic wait_tx_fall(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tx !== 1'b0 && n < limit);
  endtask

  task automatic read_reply(output logic [10:0] bits);
    repeat (BIT_CYC / 2) @(posedge clk);
    #1 bits[0] = tx;
    for (int i = 1; i < 11; i++) begin
      repeat (BIT_CYC) @(posedge clk);
      #1 bits[i] = tx;
    end
  endtask

  task automatic wait_busy_low(input int limit, output int n);
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n, w0, p0, f0;
    logic [10:0] reply;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_tx", tx, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_wr_pulse", wr_pulse, 0);
    check_output("rst_err_parity", err_parity, 0);
    check_output("rst_err_frame", err_frame, 0);
    dbg_addr = 7'h05;
    #1 check_output("rst_reg5", dbg_data, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("[TB] write 0x12 to 0x05");
    apply_stimulus(8'h85, 1'b0, 1'b1);
    apply_stimulus(8'h12, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_output("wr_count", wr_count, 1);
    check_output("wr_addr", last_wr_addr, 7'h05);
    check_output("wr_data", last_wr_data, 8'h12);
    check_output("reg5_after_wr", dbg_data, 8'h12);
    check_output("busy_after_wr", busy, 0);

    $display("[TB] read 0x05");
    apply_stimulus(8'h05, 1'b0, 1'b1);
    wait_tx_fall(200, n);
    check_output("reply_start_delay", n, 20);
    check_output("busy_in_reply", busy, 1);
    read_reply(reply);
    check_output("reply_start_bit", reply[0], 0);
    check_output("reply_data", reply[8:1], 8'h12);
    check_output("reply_parity", reply[9], 1);
    check_output("reply_stop", reply[10], 1);
    wait_busy_low(1000, n);
    check_output("busy_after_reply", busy, 0);

    $display("[TB] corrupted parity");
    w0 = wr_count; p0 = perr_count; f0 = ferr_count;
    apply_stimulus(8'h85, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_output("perr_count", perr_count, p0 + 1);
    check_output("perr_no_ferr", ferr_count, f0);
    check_output("perr_busy", busy, 0);
    check_output("perr_no_write", wr_count, w0);

    $display("[TB] write-data timeout");
    f0 = ferr_count;
    apply_stimulus(8'h83, 1'b0, 1'b1);
    n = 0;
    while (ferr_count == f0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("timeout_ferr", ferr_count, f0 + 1);
    check_output("timeout_delay", ferr_cyc - busy_rise_cyc, 2000);
    check_output("timeout_busy", busy_at_ferr, 0);
    check_output("timeout_no_write", wr_count, w0);
    dbg_addr = 7'h03;
    #1 check_output("timeout_reg3", dbg_data, 8'h00);

    $display("[TB] glitch");
    p0 = perr_count; f0 = ferr_count;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (100) @(posedge clk);
    #1 rx = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    check_output("glitch_busy", busy, 0);
    check_output("glitch_perr", perr_count, p0);
    check_output("glitch_ferr", ferr_count, f0);
    check_output("glitch_no_write", wr_count, w0);
    check_output("glitch_tx", tx, 1);

    $display("[TB] bad stop bit");
    apply_stimulus(8'h85, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b0);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_output("stop_ferr", ferr_count, f0 + 1);
    check_output("stop_perr", perr_count, p0);
    check_output("stop_no_write", wr_count, w0);
    check_output("stop_busy", busy, 0);
    dbg_addr = 7'h05;
    #1 check_output("stop_reg5", dbg_data, 8'h12);

    $display("[TB] reset during reply");
    apply_stimulus(8'hFF, 1'b0, 1'b1);
    apply_stimulus(8'hA5, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_output("wr7f_count", wr_count, w0 + 1);
    check_output("wr7f_addr", last_wr_addr, 7'h7F);
    check_output("wr7f_data", last_wr_data, 8'hA5);
    apply_stimulus(8'h7F, 1'b0, 1'b1);
    wait_tx_fall(200, n);
    check_output("rd7f_start_delay", n, 20);
    repeat (1000) @(posedge clk);
    #1;
    check_output("rd7f_bit1_low", tx, 0);
    check_output("rd7f_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_tx", tx, 1);
    check_output("async_rst_busy", busy, 0);
    dbg_addr = 7'h7F;
    #1 check_output("async_rst_reg7f", dbg_data, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_reg_slave.md
# uart_reg_slave

UART-attached register-file slave that sits directly downstream of the command UART master. It receives 8-bit odd-parity frames on `rx` (the master's `tx`), decodes `{rw, addr}` command bytes, and writes or reads a 2^ADDR_W × 8 register array. On a read, it returns one odd-parity frame on `tx` (the master's `rx`). It is the board-side endpoint used to close the master's write/read loop in simulation and on FPGA.

## Interface
- `ADDR_W`, 7: register address width; depth = 2^ADDR_W.
- `BIT_CYC`, 434: clock cycles per UART bit. The mid-bit sample point is `BIT_CYC/2 - 1` = 216.
- `TURNAROUND`, 16: idle cycles between the end of the read command's stop bit and the reply start bit.
- `WDATA_TIMEOUT`, 2000: cycles allowed between the command stop bit and the write-data start edge.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `rx`, in, 1: serial input, idle high, asynchronous to `clk`.
- `tx`, out, 1: serial output, idle high.
- `wr_pulse`, out, 1: one-cycle strobe on each register write.
- `wr_addr`, out, ADDR_W: address of the current write. Valid when `wr_pulse` is high.
- `wr_data`, out, 8: data of the current write. Valid when `wr_pulse` is high.
- `err_parity`, out, 1: one-cycle strobe when a received byte has bad parity.
- `err_frame`, out, 1: one-cycle strobe on a bad stop bit or a write-data timeout.
- `busy`, out, 1: high whenever the command FSM is not in `WAIT_CMD`.
- `dbg_addr`, in, ADDR_W: debug read address.
- `dbg_data`, out, 8: combinational read of `regs[dbg_addr]`.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, parity bit, stop bit (1).
  - Parity is odd: parity bit = `~^data`.
- Receiver (`uart_rx_byte`):
  - `rx` passes through a 2-flop synchronizer.
  - A falling edge in `RX_IDLE` moves to `RX_START`.
  - At sample point 216, if the start bit reads 1 it is a glitch: return to `RX_IDLE` with no error.
  - `RX_DATA` shifts in 8 bits, one at each sample point.
  - `RX_PARITY` samples the parity bit and compares it to `~^data`.
  - `RX_STOP` samples the stop bit, then issues a 1-cycle `byte_vld` with `byte`, `par_ok`, `stop_ok`.
  - The receiver returns to `RX_IDLE` immediately after the stop sample. It does not wait for the full stop bit.
- Command FSM states: `WAIT_CMD`, `WAIT_WDATA`, `READ_GAP`, `TX_START`, `TX_DATA`, `TX_PARITY`, `TX_STOP`.
  - **`WAIT_CMD`**, on `byte_vld`:
    - If `par_ok` and `stop_ok` are not both set: pulse the matching error and stay in `WAIT_CMD`.
    - `byte[7]`=1: latch `addr = byte[6:0]` and go to `WAIT_WDATA`.
    - `byte[7]`=0: latch `addr`, latch `rdata = regs[addr]`, and go to `READ_GAP`.
  - **`WAIT_WDATA`**:
    - A good byte writes `regs[addr]`, pulses `wr_pulse` with `wr_addr`/`wr_data`, and returns to `WAIT_CMD`.
    - A bad byte pulses the matching error and returns to `WAIT_CMD` with no write.
    - The timeout counter runs from state entry. When it reaches `WDATA_TIMEOUT-1` with no receiver start detected, pulse `err_frame` and return to `WAIT_CMD`.
  - **`READ_GAP`**: wait `(BIT_CYC/2 - 1) + TURNAROUND` cycles, which finishes the stop bit plus the turnaround, then go to `TX_START`.
  - **`TX_START`/`TX_DATA`/`TX_PARITY`/`TX_STOP`**: each bit lasts `BIT_CYC` cycles. Drive `rdata[bit_cnt]` LSB first, then the parity bit `~^rdata`, then 1. After `TX_STOP`, return to `WAIT_CMD`.
- The receiver stays enabled during the reply. Bytes received during `READ_GAP`/`TX_*` are dropped with no error pulse.
- On any error, the register array is unchanged.

## Timing
- Reset values:
  - `tx`=1.
  - `wr_pulse`, `err_parity`, `err_frame` = 0.
  - `busy`=0.
  - All `regs`=0.
  - FSMs in `RX_IDLE`/`WAIT_CMD`; all counters 0.
- Latency:
  - `wr_pulse` and the register update occur 1 cycle after `byte_vld`.
  - `byte_vld` occurs 1 cycle after the stop sample.
- Read reply: `tx` falls exactly `(BIT_CYC/2-1)+TURNAROUND+2` cycles after the command's stop sample. The reply is 11 × `BIT_CYC` cycles long.
- The `rdata` snapshot is taken at command decode. A write landing in the same cycle cannot occur, because the FSM is single-threaded.
- The bit counter wraps 7→0 only on the last data bit. The clock counter wraps at `BIT_CYC-1`.
- Asserting `rst_n` mid-reply forces `tx`=1 asynchronously and clears `regs`.

## Structure
- Package `uart_reg_pkg`: FSM state encodings, the default `BIT_CYC` constant, and a parity function `odd_par(byte)`.
- Sub-module `uart_rx_byte`: synchronizer, receive FSM, and the `byte_vld`/`byte`/`par_ok`/`stop_ok` outputs.
- The top level holds the command FSM, the TX serializer, and the register array.

## Test plan
- Write then read:
  - Send frame 0x85 then 0x12 → `wr_pulse` with `wr_addr`=5, `wr_data`=0x12.
  - Send 0x05 → `tx` returns data 0x12 with parity bit 1 and stop bit 1.
- Corrupted parity: send 0x85 with a corrupted parity bit → `err_parity` pulses once, FSM stays in `WAIT_CMD`, no write.
- Write-data timeout: send 0x83 and no second byte → `err_frame` pulses `WDATA_TIMEOUT` cycles later, `busy` drops, `regs[3]` stays 0.
- Glitch rejection: a 100-cycle low glitch on `rx` → no `byte_vld`, no errors, `busy`=0.
- Bad stop bit: send 0x85, 0x00 with the second stop bit forced to 0 → `err_frame` pulses, `regs[5]` is unchanged.
- Reset mid-reply: read of `regs[0x7F]`=0xA5, then assert `rst_n` during `TX_DATA` → `tx`=1 immediately, `dbg_data` for 0x7F = 0.
